thread_sched: RTL and testbench

- Per-thread issue scheduler for the md5crypt engine. Tracks an IDLE/READY/RUN state for every engine thread.
- Walks a thread pointer in the engine's fixed interleave order and issues READY threads to the engine over a valid/ready handshake.
- Sits between the thread-loading logic, which marks threads ready, and the engine core pipeline, which accepts issues and reports thread completion.

---
 rtl/thread_sched.sv | 141 ++++++++++++++
 tb/tb_thread_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_sched.sv
// Per-thread IDLE/READY/RUN tracker that walks the engine interleave order and
// issues READY threads to the engine core over a valid/ready handshake.
module thread_sched #(
  parameter int unsigned N_CORES   = 3,
  parameter int unsigned N_THREADS = 4 * N_CORES,
  parameter int unsigned TW        = $clog2(N_THREADS),
  localparam int unsigned CW       = $clog2(N_THREADS + 1)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          ready_wr,
  input  logic [TW-1:0] ready_num,
  input  logic          done_wr,
  input  logic [TW-1:0] done_num,
  output logic          issue_valid,
  output logic [TW-1:0] issue_num,
  input  logic          issue_ready,
  output logic [CW-1:0] busy_cnt,
  output logic          all_idle,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2
  } thr_state_e;

  thr_state_e    r_state [N_THREADS];
  logic [TW-1:0] r_ptr;
  logic          r_issue_valid;
  logic [TW-1:0] r_issue_num;
  logic [CW-1:0] r_busy_cnt;
  logic          r_all_idle;
  logic          r_err;

  thr_state_e    w_state_nxt [N_THREADS];
  logic          w_slot_free;
  logic          w_ptr_rdy;
  logic          w_issue;
  logic          w_done_hit;
  logic          w_ready_hit;
  logic          w_inc;
  logic          w_dec;
  logic          w_err;
  logic [CW-1:0] w_busy_nxt;

  // Interleave order: walk cores/contexts, then flip the sequence slot.
  function automatic logic [TW-1:0] f_next(input logic [TW-1:0] p);
    logic [TW-2:0] c;
    c = p[TW-1:1];
    if (c == (TW-1)'(2 * N_CORES - 1)) begin
      f_next = {(TW-1)'(0), ~p[0]};
    end else begin
      f_next = {c + (TW-1)'(1), p[0]};
    end
  endfunction

  // Next thread states: done, then ready, then issue, each seeing the previous result.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_rdy   = 1'b0;
    w_done_hit  = 1'b0;
    w_ready_hit = 1'b0;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_err       = 1'b0;
    w_slot_free = !r_issue_valid || issue_ready;

    for (int i = 0; i < int'(N_THREADS); i++) begin
      if (r_ptr == TW'(i) && r_state[i] == ST_READY) w_ptr_rdy = 1'b1;
    end
    w_issue = w_slot_free && w_ptr_rdy;

    if (done_wr) begin
      for (int i = 0; i < int'(N_THREADS); i++) begin
        if (done_num == TW'(i)) begin
          w_done_hit = 1'b1;
          if (w_state_nxt[i] == ST_RUN) begin
            w_state_nxt[i] = ST_IDLE;
            w_dec          = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      if (!w_done_hit) w_err = 1'b1;
    end

    if (ready_wr) begin
      for (int i = 0; i < int'(N_THREADS); i++) begin
        if (ready_num == TW'(i)) begin
          w_ready_hit = 1'b1;
          if (w_state_nxt[i] == ST_IDLE) begin
            w_state_nxt[i] = ST_READY;
            w_inc          = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      if (!w_ready_hit) w_err = 1'b1;
    end

    for (int i = 0; i < int'(N_THREADS); i++) begin
      if (w_issue && r_ptr == TW'(i)) w_state_nxt[i] = ST_RUN;
    end

    w_busy_nxt = r_busy_cnt + CW'(w_inc) - CW'(w_dec);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_THREADS); i++) r_state[i] <= ST_IDLE;
      r_ptr         <= '0;
      r_issue_valid <= 1'b0;
      r_issue_num   <= '0;
      r_busy_cnt    <= '0;
      r_all_idle    <= 1'b1;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // A stalled offer freezes the pointer and the offered thread.
      if (w_slot_free) begin
        r_issue_valid <= w_ptr_rdy;
        if (w_ptr_rdy) r_issue_num <= r_ptr;
        r_ptr <= f_next(r_ptr);
      end
      r_busy_cnt <= w_busy_nxt;
      r_all_idle <= (w_busy_nxt == '0);
      r_err      <= r_err | w_err;
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_num   = r_issue_num;
  assign busy_cnt    = r_busy_cnt;
  assign all_idle    = r_all_idle;
  assign err         = r_err;

endmodule

// File: tb/tb_thread_sched.sv
// Scoreboard bench for thread_sched: expected issue numbers are queued as
// threads are made ready and compared as the engine accepts each issue.
module tb_thread_sched;

  localparam int unsigned TW = 4;
  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          ready_wr = 1'b0;
  logic [TW-1:0] ready_num = '0;
  logic          done_wr = 1'b0;
  logic [TW-1:0] done_num = '0;
  logic          issue_valid;
  logic [TW-1:0] issue_num;
  logic          issue_ready = 1'b1;
  logic [CW-1:0] busy_cnt;
  logic          all_idle;
  logic          err;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned exp_q[$];
  int unsigned exp_v;
  int unsigned order[12] = '{0, 2, 4, 6, 8, 10, 1, 3, 5, 7, 9, 11};

  thread_sched dut (
    .CLK         (CLK),
    .reset       (reset),
    .ready_wr    (ready_wr),
    .ready_num   (ready_num),
    .done_wr     (done_wr),
    .done_num    (done_num),
    .issue_valid (issue_valid),
    .issue_num   (issue_num),
    .issue_ready (issue_ready),
    .busy_cnt    (busy_cnt),
    .all_idle    (all_idle),
    .err         (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge and take effect on the next edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ready_wr = 1'b0;
    done_wr  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic mark_ready(input int unsigned t);
    ready_wr  = 1'b1;
    ready_num = TW'(t);
    step();
    ready_wr  = 1'b0;
  endtask

  task automatic mark_done(input int unsigned t);
    done_wr  = 1'b1;
    done_num = TW'(t);
    step();
    done_wr  = 1'b0;
  endtask

  // Each accepted issue must be the oldest expected thread.
  always @(negedge CLK) begin
    if (!reset && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        chk("issue_unexp", 32'(issue_num), 32'hffff_ffff);
      end else begin
        exp_v = exp_q.pop_front();
        chk("issue_num", 32'(issue_num), exp_v);
      end
    end
  end

  initial begin
    int vcnt;

    step();
    step();
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_num", 32'(issue_num), 32'd0);
    chk("rst_busy", 32'(busy_cnt), 32'd0);
    chk("rst_idle", 32'(all_idle), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // Ready all threads in pointer order just behind the pointer; the next lap issues them in order.
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back(order[k]);
      mark_ready(order[k]);
    end
    chk("s1_busy_peak", 32'(busy_cnt), 32'd12);
    chk("s1_idle", 32'(all_idle), 32'd0);
    wait_drain(30);
    for (int t = 0; t < 12; t++) mark_done(t);
    chk("s1_busy_end", 32'(busy_cnt), 32'd0);
    chk("s1_idle_end", 32'(all_idle), 32'd1);
    chk("s1_err", 32'(err), 32'd0);

    // Only thread 5 ready: offered on the 9th edge after reset release.
    do_reset();
    exp_q.push_back(5);
    ready_wr  = 1'b1;
    ready_num = TW'(5);
    for (int k = 1; k <= 12; k++) begin
      step();
      ready_wr = 1'b0;
      chk("s2_valid", 32'(issue_valid), (k == 9) ? 32'd1 : 32'd0);
      if (k == 9) chk("s2_num", 32'(issue_num), 32'd5);
    end
    chk("s2_drain", 32'(exp_q.size()), 32'd0);
    mark_done(5);
    chk("s2_busy", 32'(busy_cnt), 32'd0);

    // Stall thread 3 for four cycles, then thread 5 follows directly.
    do_reset();
    issue_ready = 1'b0;
    exp_q.push_back(3);
    exp_q.push_back(5);
    mark_ready(3);
    mark_ready(5);
    for (int k = 3; k <= 7; k++) step();
    for (int k = 8; k <= 12; k++) begin
      step();
      chk("s3_hold_v", 32'(issue_valid), 32'd1);
      chk("s3_hold_n", 32'(issue_num), 32'd3);
    end
    issue_ready = 1'b1;
    step();
    chk("s3_next_v", 32'(issue_valid), 32'd1);
    chk("s3_next_n", 32'(issue_num), 32'd5);
    wait_drain(5);
    mark_done(3);
    mark_done(5);
    chk("s3_busy", 32'(busy_cnt), 32'd0);

    // done and ready on the same RUN thread: it returns to READY.
    do_reset();
    exp_q.push_back(7);
    mark_ready(7);
    wait_drain(20);
    chk("s4_busy_run", 32'(busy_cnt), 32'd1);
    exp_q.push_back(7);
    done_wr   = 1'b1;
    done_num  = TW'(7);
    ready_wr  = 1'b1;
    ready_num = TW'(7);
    step();
    done_wr  = 1'b0;
    ready_wr = 1'b0;
    chk("s4_busy", 32'(busy_cnt), 32'd1);
    chk("s4_err", 32'(err), 32'd0);
    wait_drain(20);
    mark_done(7);
    chk("s4_busy_end", 32'(busy_cnt), 32'd0);
    chk("s4_err_end", 32'(err), 32'd0);

    // Protocol errors are sticky and leave states untouched.
    do_reset();
    exp_q.push_back(4);
    mark_ready(4);
    chk("s5_err0", 32'(err), 32'd0);
    mark_ready(4);
    chk("s5_err1", 32'(err), 32'd1);
    chk("s5_busy1", 32'(busy_cnt), 32'd1);
    mark_done(9);
    chk("s5_err2", 32'(err), 32'd1);
    chk("s5_busy2", 32'(busy_cnt), 32'd1);
    mark_ready(13);
    chk("s5_err3", 32'(err), 32'd1);
    chk("s5_busy3", 32'(busy_cnt), 32'd1);
    chk("s5_idle3", 32'(all_idle), 32'd0);
    wait_drain(5);
    mark_done(4);
    chk("s5_busy4", 32'(busy_cnt), 32'd0);
    chk("s5_idle4", 32'(all_idle), 32'd1);
    chk("s5_err4", 32'(err), 32'd1);

    // Reset while an issue is pending with six threads busy.
    do_reset();
    issue_ready = 1'b0;
    for (int k = 0; k < 6; k++) mark_ready(order[k]);
    for (int k = 7; k <= 13; k++) step();
    chk("s6_pre_v", 32'(issue_valid), 32'd1);
    chk("s6_pre_n", 32'(issue_num), 32'd0);
    chk("s6_pre_busy", 32'(busy_cnt), 32'd6);
    reset = 1'b1;
    #1;
    chk("s6_rst_v", 32'(issue_valid), 32'd0);
    chk("s6_rst_busy", 32'(busy_cnt), 32'd0);
    chk("s6_rst_idle", 32'(all_idle), 32'd1);
    chk("s6_rst_err", 32'(err), 32'd0);
    step();
    reset       = 1'b0;
    issue_ready = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (issue_valid) vcnt++;
    end
    chk("s6_no_issue", 32'(vcnt), 32'd0);
    exp_q.push_back(2);
    mark_ready(2);
    wait_drain(20);
    mark_done(2);
    chk("s6_busy_end", 32'(busy_cnt), 32'd0);
    chk("s6_err_end", 32'(err), 32'd0);

    step();
    chk("final_q", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
